rotor_return_path: RTL and testbench

- Reverse (reflector-to-plugboard) path of one Enigma rotor.
- Accepts a letter code from the reflector side and applies the inverse rotor wiring at the current rotor position. Emits the result toward the plugboard.
- Owns the rotor position register: stepping, carry-out to the next rotor, and loading of the start position.
- Valid/ready streaming on both sides with a 2-stage pipeline.

---
 rtl/enigma_pkg.sv | 42 ++++
 rtl/rotor_position_ctr.sv | 36 +++
 rtl/rotor_return_path.sv | 91 +++++++++
 tb/tb_rotor_return_path.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared letter type, rotor I/II/III wirings (forward and derived inverse), notches, mod-26 helpers.
package enigma_pkg;
    typedef logic [4:0] letter_t;
    typedef letter_t [0:25] wiring_t;

    localparam int NUM_LETTERS = 26;
    localparam int NOTCH_I   = 16;
    localparam int NOTCH_II  = 4;
    localparam int NOTCH_III = 21;

    localparam wiring_t FWD_I = {
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
        5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
    localparam wiring_t FWD_II = {
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
        5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
    localparam wiring_t FWD_III = {
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
        5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};

    // Inverse tables are derived at elaboration so they can never drift from the forward wiring.
    function automatic wiring_t invert(wiring_t f);
        wiring_t r;
        r = '0;
        for (int i = 0; i < NUM_LETTERS; i++) r[f[i]] = letter_t'(i);
        return r;
    endfunction

    localparam wiring_t INV_I   = invert(FWD_I);
    localparam wiring_t INV_II  = invert(FWD_II);
    localparam wiring_t INV_III = invert(FWD_III);

    function automatic letter_t add_mod26(letter_t a, letter_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s >= 6'd26 ? letter_t'(s - 6'd26) : s[4:0];
    endfunction

    function automatic letter_t sub_mod26(letter_t a, letter_t b);
        return a >= b ? a - b : a + 5'd26 - b;
    endfunction
endpackage

// File: rtl/rotor_position_ctr.sv
// rotor_position_ctr: rotor position register with load, mod-26 stepping and notch carry pulse.
module rotor_position_ctr
    import enigma_pkg::*;
#(
    parameter int NOTCH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       cfg_load,
    input  logic [4:0] cfg_pos,
    output logic [4:0] pos,
    output logic       carry
);
    letter_t pos_q, pos_d;
    logic    carry_q, carry_d;

    always_comb begin
        pos_d   = cfg_load ? (cfg_pos >= letter_t'(NUM_LETTERS) ? '0 : cfg_pos)
                : step ? add_mod26(pos_q, 5'd1) : pos_q;
        carry_d = !cfg_load && step && pos_q == letter_t'(NOTCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            carry_q <= carry_d;
        end
    end

    assign pos   = pos_q;
    assign carry = carry_q;
endmodule

// File: rtl/rotor_return_path.sv
// rotor_return_path: reflector-to-plugboard inverse rotor mapping, 2-stage valid/ready pipeline.
// Optional RING_SETTING_EN adds a ring input; offset becomes (pos - ring) mod 26.
module rotor_return_path
    import enigma_pkg::*;
#(
    parameter int ROTOR_ID = 0,
    parameter int NOTCH    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_letter,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_letter,
    output logic       out_err,
    input  logic       step,
    input  logic       cfg_load,
    input  logic [4:0] cfg_pos,
`ifdef RING_SETTING_EN
    input  logic [4:0] ring,
`endif
    output logic [4:0] pos,
    output logic       carry
);
    localparam wiring_t INV = ROTOR_ID == 1 ? INV_II : ROTOR_ID == 2 ? INV_III : INV_I;

    logic    adv, in_err;
    letter_t off;
    logic    s1_valid_q, s1_err_q, s1_err_d;
    letter_t s1_idx_q, s1_idx_d, s1_off_q;
    logic    out_valid_q, out_err_q, out_err_d;
    letter_t out_letter_q, out_letter_d;

    rotor_position_ctr #(.NOTCH(NOTCH)) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (step),
        .cfg_load (cfg_load),
        .cfg_pos  (cfg_pos),
        .pos      (pos),
        .carry    (carry)
    );

`ifdef RING_SETTING_EN
    assign off = sub_mod26(pos, ring >= letter_t'(NUM_LETTERS) ? '0 : ring);
`else
    assign off = pos;
`endif

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign in_err   = in_letter >= letter_t'(NUM_LETTERS);

    // Error letters skip the lookup, so their index is parked at 0 to stay inside the table.
    always_comb begin
        s1_err_d     = in_err;
        s1_idx_d     = in_err ? '0 : add_mod26(in_letter, off);
        out_err_d    = s1_err_q;
        out_letter_d = s1_err_q ? 5'd31 : sub_mod26(INV[s1_idx_q], s1_off_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_idx_q     <= '0;
            s1_off_q     <= '0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
            out_letter_q <= '0;
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q;
            if (in_valid) begin
                s1_err_q <= s1_err_d;
                s1_idx_q <= s1_idx_d;
                s1_off_q <= off;
            end
            if (s1_valid_q) begin
                out_err_q    <= out_err_d;
                out_letter_q <= out_letter_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_letter = out_letter_q;
    assign out_err    = out_err_q;
endmodule

// File: tb/tb_rotor_return_path.sv
// tb_rotor_return_path: table vectors, corner sequences and random traffic against a forward-wiring search model.
module tb_rotor_return_path;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b1, step = 1'b0, cfg_load = 1'b0;
    logic [4:0] in_letter = '0, cfg_pos = '0;
    logic       in_ready, out_valid, out_err, carry;
    logic [4:0] out_letter, pos;
`ifdef RING_SETTING_EN
    logic [4:0] ring = '0;
`endif

    always #5 clk = ~clk;

    rotor_return_path #(.ROTOR_ID(0), .NOTCH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_letter  (in_letter),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_letter (out_letter),
        .out_err    (out_err),
        .step       (step),
        .cfg_load   (cfg_load),
        .cfg_pos    (cfg_pos),
`ifdef RING_SETTING_EN
        .ring       (ring),
`endif
        .pos        (pos),
        .carry      (carry)
    );

    typedef struct {
        logic [4:0] l;
        logic       e;
    } exp_t;

    typedef struct {
        logic [4:0] cp;
        logic [4:0] l;
        logic [4:0] el;
        logic       ee;
    } vec_t;

    exp_t  q[$];
    int    n_cmp = 0, n_bad = 0, cyc = 0, n_pop = 0, got_cyc = -1, mpos = 0, cur_ring = 0;
    logic  mcarry = 1'b0, accepted = 1'b0, got_e;
    logic [4:0] got_l;
    string fwd = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output is the letter x whose forward path at offset e reaches the input letter.
    function automatic exp_t model(input int letter, input int p, input int r);
        exp_t x;
        int   e;
        x.e = letter >= 26;
        x.l = 5'd31;
        e = (p - (r >= 26 ? 0 : r) + 26) % 26;
        if (!x.e)
            for (int i = 0; i < 26; i++)
                if (((fwd.getc((i + e) % 26) - 65) - e + 26) % 26 == letter) x.l = 5'(i);
        return x;
    endfunction

    task automatic tick();
        exp_t x;
        @(negedge clk);
        chk("pos", pos, mpos);
        chk("carry", carry, mcarry);
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                x = q.pop_front();
                chk("out_letter", out_letter, x.l);
                chk("out_err", out_err, x.e);
                got_l = out_letter;
                got_e = out_err;
                got_cyc = cyc;
                n_pop++;
            end
        end
`ifdef RING_SETTING_EN
        cur_ring = ring;
`else
        cur_ring = 0;
`endif
        accepted = in_valid && in_ready;
        if (accepted) q.push_back(model(in_letter, mpos, cur_ring));
        mcarry = !cfg_load && step && mpos == 16;
        mpos = cfg_load ? (cfg_pos >= 26 ? 0 : cfg_pos) : step ? (mpos + 1) % 26 : mpos;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic put(input logic v, input logic [4:0] l, input logic st, input logic ld, input logic [4:0] cp);
        in_valid = v; in_letter = l; step = st; cfg_load = ld; cfg_pos = cp;
        tick();
        in_valid = 1'b0; step = 1'b0; cfg_load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic single(input string name, input vec_t v);
        int acc;
        put(1'b0, 5'd0, 1'b0, 1'b1, v.cp);
        got_cyc = -1;
        acc = cyc;
        put(1'b1, v.l, 1'b0, 1'b0, 5'd0);
        idle(4);
        chk({name, "_latency"}, got_cyc - acc, 2);
        chk({name, "_letter"}, got_l, v.el);
        chk({name, "_err"}, got_e, v.ee);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        int   in_seq[3];
        int   k, lo_ready;
        vecs[0] = '{5'd0,  5'd4,  5'd0,  1'b0};
        vecs[1] = '{5'd1,  5'd3,  5'd25, 1'b0};
        vecs[2] = '{5'd0,  5'd0,  5'd20, 1'b0};
        vecs[3] = '{5'd0,  5'd9,  5'd25, 1'b0};
        vecs[4] = '{5'd30, 5'd4,  5'd0,  1'b0};
        vecs[5] = '{5'd0,  5'd27, 5'd31, 1'b1};
        vecs[6] = '{5'd5,  5'd31, 5'd31, 1'b1};

        #12;
        chk("rst_pos", pos, 0);
        chk("rst_carry", carry, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_letter", out_letter, 0);
        chk("rst_out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) single($sformatf("vec%0d", i), vecs[i]);

        put(1'b0, 5'd0, 1'b0, 1'b1, 5'd25);
        put(1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
        chk("wrap_pos", pos, 0);
        chk("wrap_carry", carry, 0);
        put(1'b0, 5'd0, 1'b0, 1'b1, 5'd16);
        put(1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
        chk("notch_pos", pos, 17);
        chk("notch_carry_hi", carry, 1);
        idle(1);
        chk("notch_carry_lo", carry, 0);
        put(1'b0, 5'd0, 1'b0, 1'b1, 5'd16);
        put(1'b0, 5'd0, 1'b0, 1'b1, 5'd16);
        chk("load_no_carry", carry, 0);

        put(1'b0, 5'd0, 1'b0, 1'b1, 5'd0);
        got_cyc = -1;
        put(1'b1, 5'd4, 1'b1, 1'b0, 5'd0);
        idle(3);
        chk("step_accept_letter", got_l, 0);
        chk("step_accept_pos", pos, 1);

        in_seq = '{7, 8, 9};
        k = 0;
        lo_ready = 1;
        n_pop = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = k < 3;
            in_letter = 5'(in_seq[k < 3 ? k : 2]);
            tick();
            if (accepted) k++;
            if (!in_ready) lo_ready = 0;
        end
        chk("bp_in_ready_dropped", lo_ready, 0);
        chk("bp_no_out_during_stall", n_pop, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 3; c++) begin
            in_valid = 1'b1;
            in_letter = 5'(in_seq[k]);
            tick();
            if (accepted) k++;
        end
        in_valid = 1'b0;
        idle(4);
        chk("bp_all_accepted", k, 3);
        chk("bp_all_emerged", n_pop, 3);

`ifdef RING_SETTING_EN
        ring = 5'd1;
        single("ring1_pos1", '{5'd1, 5'd4, 5'd0, 1'b0});
        ring = 5'd27;
        single("ring27_pos0", '{5'd0, 5'd4, 5'd0, 1'b0});
        ring = 5'd0;
`endif

        put(1'b1, 5'd5, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_pos", pos, 0);
        q.delete();
        mpos = 0;
        mcarry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_pop = 0;
        idle(3);
        chk("midrst_no_out", n_pop, 0);

        for (int c = 0; c < 600; c++) begin
            in_valid  = $urandom_range(0, 99) < 70;
            in_letter = 5'($urandom_range(0, 31));
            out_ready = $urandom_range(0, 99) < 70;
            step      = $urandom_range(0, 99) < 25;
            cfg_load  = $urandom_range(0, 99) < 5;
            cfg_pos   = 5'($urandom_range(0, 31));
`ifdef RING_SETTING_EN
            ring      = 5'($urandom_range(0, 31));
`endif
            tick();
        end
        in_valid = 1'b0; step = 1'b0; cfg_load = 1'b0; out_ready = 1'b1;
        idle(4);
        chk("rand_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
